// File: rtl/uart_sample_assembler.sv
// Packs UART bytes into BYTES_PER_SAMPLE-byte samples tagged with a round-robin channel; `SYNC_HDR_EN adds header hunt.
// Latency: sample presented one cycle after the strobe of its final byte.
// Backpressure: output held until acked; a sample completing while one is still held is dropped (out_overrun).
module uart_sample_assembler #(
    parameter int         BYTES_PER_SAMPLE = 2,
    parameter int         CHANNELS         = 2,
    parameter bit         LITTLE_ENDIAN    = 1'b1,
    parameter int         TIMEOUT_CYCLES   = 1000,
    parameter logic [7:0] SYNC_BYTE        = 8'hA5,
    localparam int        SW               = 8 * BYTES_PER_SAMPLE,
    localparam int        CW               = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic          in_clk,
    input  logic          in_rst_n,
    input  logic          in_uart_ready,
    input  logic [7:0]    in_uart_frame,
    output logic [SW-1:0] out_frame,
    output logic [CW-1:0] out_channel,
    output logic          out_last,
    output logic          out_ready,
    input  logic          in_sample_ack,
    output logic          out_overrun,
    output logic          out_timeout
);

    localparam int BW = (BYTES_PER_SAMPLE > 1) ? $clog2(BYTES_PER_SAMPLE) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES_PER_SAMPLE - 1);
    localparam logic [CW-1:0] LAST_CH   = CW'(CHANNELS - 1);

    logic [SW-1:0] shadow_q, shadow_d;
    logic [BW-1:0] byte_idx_q, byte_idx_d;
    logic [CW-1:0] ch_idx_q, ch_idx_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [SW-1:0] out_frame_q, out_frame_d;
    logic [CW-1:0] out_channel_q, out_channel_d;
    logic          out_last_q, out_last_d;
    logic          out_ready_q, out_ready_d;
    logic          out_overrun_q, out_overrun_d;
    logic          out_timeout_q, out_timeout_d;

    logic          in_collect;
    logic          accept;
    logic          complete;
    logic          active;
    logic          timeout_fire;
    logic [BW-1:0] slot;
    logic [SW-1:0] assembled;

`ifdef SYNC_HDR_EN
    typedef enum logic {HUNT, COLLECT} state_e;
    state_e state_q, state_d;
    assign in_collect = (state_q == COLLECT);
`else
    assign in_collect = 1'b1;
`endif

    assign accept   = in_uart_ready && in_collect;
    assign complete = accept && (byte_idx_q == LAST_BYTE);
    assign active   = (byte_idx_q != '0) || (ch_idx_q != '0);
    assign slot     = LITTLE_ENDIAN ? byte_idx_q : (LAST_BYTE - byte_idx_q);

    // A strobe in the terminal idle cycle takes precedence over the timeout.
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_tmo
            localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
            assign timeout_fire = !in_uart_ready && active && (tmo_cnt_q == TMO_LAST);
        end else begin : g_no_tmo
            assign timeout_fire = 1'b0;
        end
    endgenerate

    always_comb begin
        assembled = shadow_q;
        assembled[{slot, 3'b000} +: 8] = in_uart_frame;
    end

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (in_uart_ready || timeout_fire) begin
            tmo_cnt_d = '0;
        end else if (active && (TIMEOUT_CYCLES > 0)) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_comb begin
        shadow_d      = shadow_q;
        byte_idx_d    = byte_idx_q;
        ch_idx_d      = ch_idx_q;
        out_frame_d   = out_frame_q;
        out_channel_d = out_channel_q;
        out_last_d    = out_last_q;
        out_ready_d   = out_ready_q;
        out_overrun_d = 1'b0;
        out_timeout_d = timeout_fire;
        if (out_ready_q && in_sample_ack) begin
            out_ready_d = 1'b0;
        end
        if (accept) begin
            shadow_d   = assembled;
            byte_idx_d = complete ? '0 : (byte_idx_q + 1'b1);
        end
        if (complete) begin
            ch_idx_d = (ch_idx_q == LAST_CH) ? '0 : (ch_idx_q + 1'b1);
            // The held sample wins; the channel slot is still consumed to keep interleave alignment.
            if (out_ready_q && !in_sample_ack) begin
                out_overrun_d = 1'b1;
            end else begin
                out_frame_d   = assembled;
                out_channel_d = ch_idx_q;
                out_last_d    = (ch_idx_q == LAST_CH);
                out_ready_d   = 1'b1;
            end
        end
        if (timeout_fire) begin
            byte_idx_d = '0;
            ch_idx_d   = '0;
        end
    end

`ifdef SYNC_HDR_EN
    always_comb begin
        state_d = state_q;
        if (timeout_fire) begin
            state_d = HUNT;
        end else if (state_q == HUNT) begin
            if (in_uart_ready && (in_uart_frame == SYNC_BYTE)) begin
                state_d = COLLECT;
            end
        end else if (complete && (ch_idx_q == LAST_CH)) begin
            state_d = HUNT;
        end
    end
`endif

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            shadow_q      <= '0;
            byte_idx_q    <= '0;
            ch_idx_q      <= '0;
            tmo_cnt_q     <= '0;
            out_frame_q   <= '0;
            out_channel_q <= '0;
            out_last_q    <= 1'b0;
            out_ready_q   <= 1'b0;
            out_overrun_q <= 1'b0;
            out_timeout_q <= 1'b0;
`ifdef SYNC_HDR_EN
            state_q       <= HUNT;
`endif
        end else begin
            shadow_q      <= shadow_d;
            byte_idx_q    <= byte_idx_d;
            ch_idx_q      <= ch_idx_d;
            tmo_cnt_q     <= tmo_cnt_d;
            out_frame_q   <= out_frame_d;
            out_channel_q <= out_channel_d;
            out_last_q    <= out_last_d;
            out_ready_q   <= out_ready_d;
            out_overrun_q <= out_overrun_d;
            out_timeout_q <= out_timeout_d;
`ifdef SYNC_HDR_EN
            state_q       <= state_d;
`endif
        end
    end

    assign out_frame   = out_frame_q;
    assign out_channel = out_channel_q;
    assign out_last    = out_last_q;
    assign out_ready   = out_ready_q;
    assign out_overrun = out_overrun_q;
    assign out_timeout = out_timeout_q;

endmodule

// File: tb/tb_uart_sample_assembler.sv
// Bench for uart_sample_assembler: three parameter sets, each with a byte-queue reference model,
// a scoreboard of expected transfers/pulses tagged with their cycle, and an independent monitor.
module tb_uart_sample_assembler;

    logic in_clk   = 1'b0;
    logic in_rst_n = 1'b0;
    always #5 in_clk = ~in_clk;

    int cyc = 0;
    always @(posedge in_clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

`ifdef SYNC_HDR_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    typedef struct {
        logic [31:0] frame;
        int          ch;
        bit          last;
        int          at;
    } exp_t;

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int ID  = g;
        localparam int BPS = (g == 0) ? 2 : (g == 1) ? 3 : 1;
        localparam int CH  = (g == 0) ? 2 : (g == 1) ? 3 : 1;
        localparam bit LE  = (g != 1);
        localparam int TMO = (g == 0) ? 20 : (g == 1) ? 7 : 5;
        localparam int SW  = 8 * BPS;
        localparam int CW  = (CH > 1) ? $clog2(CH) : 1;

        logic          strb   = 1'b0;
        logic [7:0]    byte_v = 8'h00;
        logic          ack    = 1'b0;
        logic [SW-1:0] out_frame;
        logic [CW-1:0] out_channel;
        logic          out_last;
        logic          out_ready;
        logic          out_overrun;
        logic          out_timeout;

        uart_sample_assembler #(
            .BYTES_PER_SAMPLE(BPS),
            .CHANNELS        (CH),
            .LITTLE_ENDIAN   (LE),
            .TIMEOUT_CYCLES  (TMO),
            .SYNC_BYTE       (8'hA5)
        ) dut (
            .in_clk       (in_clk),
            .in_rst_n     (in_rst_n),
            .in_uart_ready(strb),
            .in_uart_frame(byte_v),
            .out_frame    (out_frame),
            .out_channel  (out_channel),
            .out_last     (out_last),
            .out_ready    (out_ready),
            .in_sample_ack(ack),
            .out_overrun  (out_overrun),
            .out_timeout  (out_timeout)
        );

        // Reference model: bytes of the sample in progress, group position, idle count since last byte.
        logic [7:0]  part[$];
        int          chan    = 0;
        int          idle    = 0;
        bit          hunt    = SYNC;
        bit          vld     = 1'b0;
        logic [31:0] m_frame = '0;
        int          m_ch    = 0;
        bit          m_last  = 1'b0;
        exp_t        xq[$];
        int          ovq[$];
        int          toq[$];
        bit          started = 1'b0;
        bit          fin     = 1'b0;
        exp_t        e;

        // Inputs applied now take effect at the next edge; its results are visible at cycle cyc+1.
        task automatic step(input bit s, input logic [7:0] b, input bit a);
            bit          vld0;
            bit          act;
            logic [31:0] smp;
            vld0 = vld;
            act  = (part.size() != 0) || (chan != 0);
            smp  = '0;
            if (vld0 && a) begin
                xq.push_back('{m_frame, m_ch, m_last, cyc});
                vld = 1'b0;
            end
            if (s) begin
                idle = 0;
                if (hunt) begin
                    if (b == 8'hA5) hunt = 1'b0;
                end else begin
                    part.push_back(b);
                    if (part.size() == BPS) begin
                        for (int i = 0; i < BPS; i++)
                            smp = smp | (32'(part[i]) << (8 * (LE ? i : BPS - 1 - i)));
                        part.delete();
                        if (vld0 && !a) begin
                            ovq.push_back(cyc + 1);
                        end else begin
                            vld     = 1'b1;
                            m_frame = smp;
                            m_ch    = chan;
                            m_last  = (chan == CH - 1);
                        end
                        chan = (chan + 1) % CH;
                        if (SYNC && chan == 0) hunt = 1'b1;
                    end
                end
            end else if (TMO > 0 && act) begin
                idle++;
                if (idle == TMO) begin
                    part.delete();
                    chan = 0;
                    idle = 0;
                    hunt = SYNC;
                    toq.push_back(cyc + 1);
                end
            end
        endtask

        task automatic drive(input bit s, input logic [7:0] b, input bit a);
            @(posedge in_clk);
            #1;
            strb   = s;
            byte_v = b;
            ack    = a;
            step(s, b, a);
        endtask

        task automatic send(input logic [7:0] b, input bit a);
            drive(1'b1, b, a);
        endtask

        task automatic idle_n(input int n, input bit a);
            for (int i = 0; i < n; i++) drive(1'b0, 8'h00, a);
        endtask

        always @(negedge in_clk) begin
            if (in_rst_n && started && !fin) begin
                if ((out_ready && ack) || (xq.size() != 0 && xq[0].at == cyc)) begin
                    total++;
                    if (xq.size() == 0) begin
                        bad++;
                        $display("FAIL cfg%0d xfer: got frame=%h ch=%0d at cycle %0d, required no transfer",
                                 ID, out_frame, out_channel, cyc);
                    end else begin
                        e = xq.pop_front();
                        if (!(out_ready && ack) || 32'(out_frame) !== e.frame ||
                            int'(out_channel) != e.ch || out_last !== e.last) begin
                            bad++;
                            $display("FAIL cfg%0d xfer: got vld=%0b frame=%h ch=%0d last=%0b at cycle %0d, required frame=%h ch=%0d last=%0b",
                                     ID, out_ready && ack, out_frame, out_channel, out_last, cyc,
                                     e.frame, e.ch, e.last);
                        end
                    end
                end
                if (out_overrun || (ovq.size() != 0 && ovq[0] == cyc)) begin
                    total++;
                    if (!(out_overrun && ovq.size() != 0 && ovq[0] == cyc)) begin
                        bad++;
                        $display("FAIL cfg%0d overrun: got pulse=%0b at cycle %0d, required pulse at cycle %0d",
                                 ID, out_overrun, cyc, (ovq.size() != 0) ? ovq[0] : -1);
                    end
                    if (ovq.size() != 0 && ovq[0] <= cyc) void'(ovq.pop_front());
                end
                if (out_timeout || (toq.size() != 0 && toq[0] == cyc)) begin
                    total++;
                    if (!(out_timeout && toq.size() != 0 && toq[0] == cyc)) begin
                        bad++;
                        $display("FAIL cfg%0d timeout: got pulse=%0b at cycle %0d, required pulse at cycle %0d",
                                 ID, out_timeout, cyc, (toq.size() != 0) ? toq[0] : -1);
                    end
                    if (toq.size() != 0 && toq[0] <= cyc) void'(toq.pop_front());
                end
            end
        end

        initial begin
            #12;
            total++;
            if ({out_ready, out_overrun, out_timeout, out_last} !== 4'b0 || out_channel !== '0 || out_frame !== '0) begin
                bad++;
                $display("FAIL cfg%0d reset_hold: got rdy=%b ovr=%b tmo=%b last=%b ch=%h frame=%h, required all zero",
                         ID, out_ready, out_overrun, out_timeout, out_last, out_channel, out_frame);
            end
            wait (in_rst_n == 1'b1);
            @(negedge in_clk);
            total++;
            if ({out_ready, out_overrun, out_timeout, out_last} !== 4'b0 || out_channel !== '0 || out_frame !== '0) begin
                bad++;
                $display("FAIL cfg%0d reset_release: got rdy=%b ovr=%b tmo=%b last=%b ch=%h frame=%h, required all zero",
                         ID, out_ready, out_overrun, out_timeout, out_last, out_channel, out_frame);
            end
            started = 1'b1;

            // Header-framed group, then a long gap so every configuration resynchronises.
            send(8'h11, 1'b1); send(8'hA5, 1'b1); send(8'h01, 1'b1); send(8'h00, 1'b1);
            send(8'h02, 1'b1); send(8'h00, 1'b1); send(8'h03, 1'b1);
            idle_n(25, 1'b1);
            // Back-to-back bytes with the consumer always ready.
            send(8'h34, 1'b1); send(8'h12, 1'b1); send(8'h78, 1'b1); send(8'h56, 1'b1);
            idle_n(3, 1'b1);
            // Consumer stalled: second completion must overrun.
            send(8'h34, 1'b0); idle_n(1, 1'b0); send(8'h12, 1'b0); idle_n(1, 1'b0);
            send(8'h78, 1'b0); idle_n(1, 1'b0); send(8'h56, 1'b0);
            idle_n(3, 1'b0);
            idle_n(3, 1'b1);
            // Partial sample left idle past the timeout, then a fresh sample.
            send(8'h77, 1'b1);
            idle_n(25, 1'b1);
            send(8'h01, 1'b1); send(8'h02, 1'b1);
            idle_n(3, 1'b1);
            // Strobe in the terminal idle cycle of the 20-cycle timeout.
            send(8'h10, 1'b1);
            idle_n(19, 1'b1);
            send(8'h20, 1'b1);
            idle_n(3, 1'b1);

            for (int n = 0; n < 1500; n++) begin
                if ($urandom_range(0, 39) == 0) begin
                    idle_n(int'($urandom_range(15, 25)), $urandom_range(0, 3) != 0);
                end else begin
                    drive(1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom),
                          $urandom_range(0, 9) < 7);
                end
            end
            idle_n(40, 1'b1);
            @(negedge in_clk);
            #1;
            total++;
            if (xq.size() != 0 || ovq.size() != 0 || toq.size() != 0) begin
                bad++;
                $display("FAIL cfg%0d drain: got pending xfer=%0d ovr=%0d tmo=%0d, required 0 0 0",
                         ID, xq.size(), ovq.size(), toq.size());
            end
            fin = 1'b1;
        end
    end

    initial begin
        repeat (3) @(posedge in_clk);
        #1 in_rst_n = 1'b1;
        for (int i = 0; i < 30000; i++) begin
            if (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) break;
            @(posedge in_clk);
        end
        if (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin)) begin
            total++;
            bad++;
            $display("FAIL watchdog: got fin=%b%b%b, required 111",
                     g_cfg[2].fin, g_cfg[1].fin, g_cfg[0].fin);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_sample_assembler.md
Name: uart_sample_assembler

Overview:
Parametrised successor to the two-byte UART sample packer. Assembles consecutive UART bytes into samples of BYTES_PER_SAMPLE bytes, tags each sample with a round-robin channel index, and presents it on a valid/ready output. Adds inter-byte timeout resync and overrun detection. Sits between the UART receiver and the per-channel sample consumers (filters/DAC path).

Parameters:
BYTES_PER_SAMPLE, 2, bytes per sample (1..4); sample width SW = 8*BYTES_PER_SAMPLE
CHANNELS, 2, interleaved channels per group (1..16); CW = max(1, clog2(CHANNELS))
LITTLE_ENDIAN, 1, 1: first byte -> sample[7:0]; 0: first byte -> sample[SW-1:SW-8]
TIMEOUT_CYCLES, 1000, idle in_clk cycles mid-group before resync; 0 disables timeout
SYNC_BYTE, 8'hA5, group header value (used only with SYNC_HDR_EN)

Ports:
in_clk  input  1  clock, all logic on rising edge
in_rst_n  input  1  asynchronous active-low reset
in_uart_ready  input  1  one-cycle strobe, in_uart_frame valid
in_uart_frame  input  8  received UART byte
out_frame  output  SW  assembled sample
out_channel  output  CW  channel index of out_frame
out_last  output  1  out_frame is last channel of group (out_channel == CHANNELS-1)
out_ready  output  1  valid; held until accepted
in_sample_ack  input  1  consumer ready; transfer when out_ready & in_sample_ack
out_overrun  output  1  one-cycle pulse: completed sample dropped
out_timeout  output  1  one-cycle pulse: partial sample/group discarded

Behaviour:
- Reset (async assert, sync release): out_frame=0, out_channel=0, out_last=0, out_ready=0, out_overrun=0, out_timeout=0, byte index=0, channel index=0, timeout counter=0, state=COLLECT (HUNT with SYNC_HDR_EN). Reset mid-sample discards partial data.
- Byte accept: each in_uart_ready cycle in COLLECT writes in_uart_frame into shadow register at byte slot per LITTLE_ENDIAN, byte index +1.
- Completion: byte index reaching BYTES_PER_SAMPLE-1 on accept -> next edge loads out_frame/out_channel/out_last from shadow+current byte, out_ready=1; byte index ->0; channel index +1, wraps CHANNELS-1 -> 0. Latency: out_ready high one cycle after the final byte's strobe cycle.
- Handshake: out_ready & in_sample_ack on an edge -> out_ready=0 next cycle unless a new sample completes the same cycle (then new sample loaded, out_ready stays 1).
- Overrun: completion while out_ready=1 and in_sample_ack=0 -> new sample discarded, held output unchanged, channel index still advances, out_overrun=1 for one cycle.
- Timeout: counter clears on every accepted byte; counts only when byte index!=0 or channel index!=0; reaching TIMEOUT_CYCLES with no strobe that cycle -> byte index=0, channel index=0, counter=0, out_timeout pulse, state->HUNT (if enabled). Strobe in the terminal cycle wins: byte accepted, no timeout. Does not touch out_ready/out_frame.
- BYTES_PER_SAMPLE=1: every accepted byte completes a sample.
- CHANNELS=1: out_channel constant 0, out_last always 1 when valid.

Optional Feature:
SYNC_HDR_EN: defined -> states HUNT/COLLECT. HUNT discards bytes until in_uart_frame==SYNC_BYTE (header itself discarded), then COLLECT; after completing channel CHANNELS-1 returns to HUNT; timeout returns to HUNT. A SYNC_BYTE value inside COLLECT is data. Undefined -> no HUNT state, always COLLECT, SYNC_BYTE ignored, grouping by byte count only.

Test Plan:
- Defaults, bytes 34,12,78,56, ack held 1 -> out_frame 16'h1234 ch0 last0, then 16'h5678 ch1 last1; out_ready one cycle each, 1 cycle after final strobe.
- LITTLE_ENDIAN=0, BYTES_PER_SAMPLE=3, bytes AA,BB,CC -> out_frame 24'hAABBCC.
- Ack held 0, 4 bytes sent -> out_frame stays 16'h1234, out_overrun single pulse at second completion; channel wraps to 0.
- TIMEOUT_CYCLES=20, send one byte then idle 25 cycles -> out_timeout pulse at cycle 20 after byte; next bytes 01,02 -> 16'h0201 ch0.
- Strobe landing exactly on timeout terminal cycle -> no out_timeout, sample completes normally.
- SYNC_HDR_EN, bytes 11,A5,01,00,02,00 -> 11 dropped, samples 16'h0001 ch0, 16'h0002 ch1; following 03 dropped until next A5.
